despachante_cluster: RTL

DESPACHANTE_CLUSTER -- requirements
Module: despachante_cluster

---
 rtl/despachante_cluster_if.sv | 33 +++
 rtl/despachante_cluster.sv | 114 +++++++++++
 2 files changed

// File: rtl/despachante_cluster_if.sv
// Buffer-head entry, one-hot cluster request/acknowledge and status signals of despachante_cluster.
// The master modport is the dispatcher's view; slave is the buffer/cluster side.
interface despachante_cluster_if #(
    parameter int NUM_CLUSTERS  = 5,
    parameter int TAM_ENDERECO  = 64,
    parameter int TAM_HASH_DOIS = 8
);
    logic                     entrada_valida;
    logic [NUM_CLUSTERS-1:0]  bitmap_atual;
    logic [TAM_ENDERECO-1:0]  endereco_atual;
    logic [TAM_HASH_DOIS-1:0] hash_atual;
    logic [NUM_CLUSTERS-1:0]  bitmap_atualizado;
    logic                     zero;
    logic                     req_valido;
    logic [NUM_CLUSTERS-1:0]  req_cluster;
    logic [TAM_ENDERECO-1:0]  req_endereco;
    logic [TAM_HASH_DOIS-1:0] req_hash;
    logic [NUM_CLUSTERS-1:0]  ack_cluster;
    logic                     ocupado;
    logic                     erro_timeout;

    modport master (
        input  entrada_valida, bitmap_atual, endereco_atual, hash_atual, ack_cluster,
        output bitmap_atualizado, zero, req_valido, req_cluster, req_endereco, req_hash,
               ocupado, erro_timeout
    );

    modport slave (
        output entrada_valida, bitmap_atual, endereco_atual, hash_atual, ack_cluster,
        input  bitmap_atualizado, zero, req_valido, req_cluster, req_endereco, req_hash,
               ocupado, erro_timeout
    );
endinterface

// File: rtl/despachante_cluster.sv
// Walks the head entry's cluster bitmap lowest-bit first, one request per cluster, then retires it.
// Latency: first request 1 cycle after entrada_valida; zero 1 cycle after the last acknowledge.
// Backpressure: holds each request until its cluster acks; DESPACHANTE_TIMEOUT_EN adds a give-up counter.
module despachante_cluster #(
    parameter int NUM_CLUSTERS   = 5,
    parameter int TAM_ENDERECO   = 64,
    parameter int TAM_HASH_DOIS  = 8,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    despachante_cluster_if.master bus
);
    typedef enum logic [1:0] {OCIOSO, ENVIA, RETIRA} estado_t;

    estado_t                  estado_q, estado_d;
    logic [NUM_CLUSTERS-1:0]  bitmap_q, bitmap_d;
    logic [TAM_ENDERECO-1:0]  endereco_q, endereco_d;
    logic [TAM_HASH_DOIS-1:0] hash_q, hash_d;
    logic [NUM_CLUSTERS-1:0]  sel;
    logic [NUM_CLUSTERS-1:0]  restante;
    logic                     ack_sel;
    logic                     expira;
    logic                     avanca;

    // Isolate the lowest set bit: x & -x.
    assign sel      = bitmap_q & (~bitmap_q + NUM_CLUSTERS'(1));
    assign restante = bitmap_q & ~sel;
    assign ack_sel  = |(sel & bus.ack_cluster);
    assign avanca   = ack_sel | expira;

`ifdef DESPACHANTE_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [CW-1:0] cont_q, cont_d;
    logic          erro_q, erro_d;

    // A real acknowledge on the expiry edge wins, so no error is flagged.
    assign expira = (estado_q == ENVIA) && !ack_sel && (cont_q == CW'(TIMEOUT_CICLOS - 1));

    always_comb begin
        cont_d = '0;
        erro_d = 1'b0;
        if (estado_q == ENVIA) begin
            cont_d = avanca ? '0 : cont_q + CW'(1);
            erro_d = expira;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
            erro_q <= 1'b0;
        end else begin
            cont_q <= cont_d;
            erro_q <= erro_d;
        end
    end

    assign bus.erro_timeout = erro_q;
`else
    assign expira           = 1'b0;
    assign bus.erro_timeout = 1'b0;
`endif

    always_comb begin
        estado_d   = estado_q;
        bitmap_d   = bitmap_q;
        endereco_d = endereco_q;
        hash_d     = hash_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.entrada_valida) begin
                    bitmap_d   = bus.bitmap_atual;
                    endereco_d = bus.endereco_atual;
                    hash_d     = bus.hash_atual;
                    estado_d   = (|bus.bitmap_atual) ? ENVIA : RETIRA;
                end
            end
            ENVIA: begin
                if (avanca) begin
                    bitmap_d = restante;
                    if (restante == '0) begin
                        estado_d = RETIRA;
                    end
                end
            end
            RETIRA:  estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            bitmap_q   <= '0;
            endereco_q <= '0;
            hash_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            bitmap_q   <= bitmap_d;
            endereco_q <= endereco_d;
            hash_q     <= hash_d;
        end
    end

    assign bus.req_valido        = (estado_q == ENVIA);
    assign bus.req_cluster       = (estado_q == ENVIA) ? sel : '0;
    assign bus.req_endereco      = endereco_q;
    assign bus.req_hash          = hash_q;
    assign bus.zero              = (estado_q == RETIRA);
    assign bus.ocupado           = (estado_q != OCIOSO);
    assign bus.bitmap_atualizado = bitmap_q;
endmodule
